fifo_pixel_reader: RTL and testbench
====================================

Name: fifo_pixel_reader

Overview:
- Read-side consumer for the DVI pixel FIFO. It drains words from the synchronous FIFO's read port and presents one pixel per cycle of display-enable to the TMDS encoder path.
- A prefetch buffer hides the FIFO's 1-cycle read latency.
- A start-of-frame tag bit aligns FIFO contents to video timing. The block recovers from underflow and misalignment by resynchronising at the next frame.

Parameters:
- PIXEL_WIDTH, 24: pixel bits. The FIFO word is PIXEL_WIDTH+1 bits; the MSB is the SOF tag.
- CNT_WIDTH, 16: width of the saturating error counter.
- FILL_PIXEL, 24'h000000: pixel driven when no valid data is available.

Ports:
- clk  in  1: pixel clock.
- rst_n  in  1: asynchronous active-low reset.
- fifo_r_en  out  1: FIFO read strobe.
- fifo_data  in  PIXEL_WIDTH+1: FIFO registered read data, valid the cycle after an accepted read.
- fifo_empty  in  1: FIFO empty flag.
- frame_start  in  1: 1-cycle pulse from timing generator, at least 2 cycles before the first de of a frame.
- de  in  1: display enable, requests one pixel this cycle.
- de_out  out  1: de delayed 1 cycle.
- pixel_out  out  PIXEL_WIDTH: pixel aligned with de_out.
- locked  out  1: high while in STREAM.
- underflow  out  1: 1-cycle pulse on an underflow or sync error.
- err_count  out  CNT_WIDTH: saturating count of underflow and sync errors.

Behaviour:
- Reset (async assert, sync release) values:
  - fifo_r_en=0, de_out=0, pixel_out=FILL_PIXEL, locked=0, underflow=0, err_count=0.
  - Buffer empty, no read in flight, state IDLE.
- Read issue:
  - fifo_r_en=1 iff !fifo_empty and (buffered + in_flight − pop_this_cycle) < 2.
  - An issued read lands in the buffer next cycle.
  - The buffer never overflows. The block never reads while fifo_empty.
- Buffer: 2-entry FIFO of {sof, pixel}. head = oldest entry. Pop and land may occur in the same cycle.
- Output pipeline:
  - de_out <= de every cycle.
  - pixel_out <= head pixel when the cycle pops, else FILL_PIXEL.
  - Latency is 1 cycle from de.
- IDLE:
  - Discard head entries whose sof=0, one per cycle.
  - When the head has sof=1, go to ARMED without popping it.
- ARMED:
  - Hold the head. On frame_start go to STREAM.
  - de in ARMED does not pop and outputs FILL_PIXEL.
- STREAM (locked=1):
  - On de with head valid: pop the head.
    - Exception: the head has sof=1 and is not the first pop since frame_start. This is a sync error: no pop, underflow pulse, err_count+1, go to ARMED.
  - On de with buffer empty: underflow pulse, err_count+1, output FILL_PIXEL, go to RESYNC.
  - frame_start while in STREAM (the frame ended cleanly) re-arms the first-pop rule.
- RESYNC: behaves as IDLE; discard until a head with sof=1, then ARMED.
- Counter: err_count saturates at all-ones. underflow still pulses at saturation.
- Simultaneous events:
  - frame_start and de in the same cycle in ARMED: transition only, no pop.
  - A land and a pop in the same cycle keep the count unchanged.
- Async reset mid-frame: all state is discarded immediately. An in-flight FIFO read is lost and the FIFO is expected to be reset together with this block.

Decomposition:
- Shared package dvi_pkg:
  - PIXEL_WIDTH default.
  - State enum (IDLE, ARMED, STREAM, RESYNC).
  - SOF bit index constant.
- One natural sub-module, prefetch_buf2: the 2-entry buffer with push/pop/count.

Test Plan:
- Post-reset fill: FIFO holds {1,0x000001},{0,0x000002},{0,0x000003}; frame_start, then de for 3 cycles.
  - Expect pixel_out 1,2,3 with de_out, locked=1, err_count=0.
- Leading junk: words {0,0xAAAAAA}×2 then {1,0x000010}.
  - Expect both junk words discarded in IDLE and first streamed pixel 0x000010.
- Underflow: 2 words present, de held for 4 cycles.
  - Expect pixels 2, then FILL_PIXEL at the 3rd cycle, underflow pulse, err_count=1, state RESYNC, locked=0.
- Mid-frame SOF: a frame with words {1,A},{0,B},{1,C} and de for 3 cycles.
  - Expect A,B, then a sync error: C not popped, err_count+1, ARMED; the next frame_start streams C first.
- Saturation: CNT_WIDTH=2, force 5 underflows.
  - Expect err_count stuck at 3 and 5 underflow pulses.
- Async reset while STREAM with a read in flight.
  - Expect all outputs at reset values immediately, with no fifo_r_en during reset.

Source files
------------

// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI pixel read path.
//   PIXEL_WIDTH_DEF : default pixel width (bits per pixel, excluding the SOF tag)
//   SOF_BIT         : index of the start-of-frame tag in a default-width FIFO word
//   state_t         : reader FSM states
package dvi_pkg;

  localparam int PIXEL_WIDTH_DEF = 24;
  localparam int SOF_BIT         = PIXEL_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_pixel_reader_if.sv
// Read port of the synchronous pixel FIFO.
//   fifo_r_en  : read strobe, driven by the reader
//   fifo_data  : {sof, pixel}, registered read data
//   fifo_empty : FIFO empty flag
// Handshake: a read is accepted on every rising clk edge where fifo_r_en=1;
// the reader only raises fifo_r_en while fifo_empty=0, and fifo_data carries
// the accepted word during the following cycle (1-cycle read latency).
interface fifo_pixel_reader_if
  import dvi_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
);

  logic                 fifo_r_en;
  logic [PIXEL_WIDTH:0] fifo_data;
  logic                 fifo_empty;

  // master: the reader; slave: the FIFO
  modport master (output fifo_r_en, input fifo_data, input fifo_empty);
  modport slave  (input fifo_r_en, output fifo_data, output fifo_empty);

endinterface

// File: rtl/prefetch_buf2.sv
// Two-entry FIFO holding prefetched {sof, pixel} words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write push_data_i this cycle
//   push_data_i : word to store
//   pop_i       : drop the head entry this cycle
//   head_o      : oldest entry (meaningful when count_o != 0)
//   count_o     : number of valid entries (0..2)
// Push and pop may coincide; the caller guarantees no overflow/underflow.
module prefetch_buf2 #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_pixel_reader.sv
// Read-side consumer of the DVI pixel FIFO. Prefetches FIFO words into a
// 2-entry buffer, aligns them to video timing with the SOF tag, and emits one
// pixel per de cycle with 1-cycle latency. Underflow and sync errors drop the
// block out of STREAM and it resynchronises on the next SOF-tagged word.
//   clk, rst_n  : pixel clock, asynchronous active-low reset (release is
//                 expected to be synchronous to clk)
//   fifo        : FIFO read port (master side)
//   frame_start : 1-cycle pulse ahead of the first de of a frame
//   de          : display enable, one pixel requested
//   de_out      : de delayed one cycle
//   pixel_out   : pixel aligned with de_out (FILL_PIXEL when nothing popped)
//   locked      : high while streaming
//   underflow   : 1-cycle pulse on underflow or sync error
//   err_count   : saturating error counter
//   dbg_state   : current FSM state
module fifo_pixel_reader
  import dvi_pkg::*;
#(
  parameter int                     PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int                     CNT_WIDTH   = 16,
  parameter logic [PIXEL_WIDTH-1:0] FILL_PIXEL  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_pixel_reader_if.master    fifo,
  input  logic                   frame_start,
  input  logic                   de,
  output logic                   de_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   locked,
  output logic                   underflow,
  output logic [CNT_WIDTH-1:0]   err_count,
  output state_t                 dbg_state
);

  state_t                 state_q, state_d;
  logic                   first_q, first_d;   // next pop is the first of the frame
  logic                   in_flight_q;        // read issued last cycle, lands now
  logic                   de_out_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic                   underflow_q;
  logic [CNT_WIDTH-1:0]   err_q;

  logic [PIXEL_WIDTH:0]   head;
  logic [1:0]             count;
  logic                   head_valid;
  logic                   head_sof;
  logic                   disc_pop;           // discard while hunting for SOF
  logic                   out_pop;            // pop that produces a pixel
  logic                   pop;
  logic                   err_evt;
  logic [2:0]             occupancy;
  logic                   issue;

  prefetch_buf2 #(.WIDTH(PIXEL_WIDTH + 1)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_flight_q),
    .push_data_i (fifo.fifo_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign head_valid = (count != 2'd0);
  assign head_sof   = head[PIXEL_WIDTH];

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    disc_pop = 1'b0;
    out_pop  = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      IDLE, RESYNC: begin
        if (head_valid) begin
          if (head_sof) state_d = ARMED;
          else          disc_pop = 1'b1;
        end
      end
      ARMED: begin
        // de here never pops; a coincident frame_start only transitions
        if (frame_start) begin
          state_d = STREAM;
          first_d = 1'b1;
        end
      end
      STREAM: begin
        if (de) begin
          if (!head_valid) begin
            err_evt = 1'b1;
            state_d = RESYNC;
          end else if (head_sof && !first_q) begin
            // next frame's data reached the head early: keep it and re-arm
            err_evt = 1'b1;
            state_d = ARMED;
          end else begin
            out_pop = 1'b1;
            first_d = 1'b0;
          end
        end
        if (frame_start) first_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = disc_pop | out_pop;

  // Entries held or already on their way, after this cycle's pop.
  assign occupancy = {1'b0, count} + {2'b00, in_flight_q} - {2'b00, pop};
  assign issue     = rst_n && !fifo.fifo_empty && (occupancy < 3'd2);

  assign fifo.fifo_r_en = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      in_flight_q <= 1'b0;
      de_out_q    <= 1'b0;
      pixel_q     <= FILL_PIXEL;
      underflow_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      in_flight_q <= issue;
      de_out_q    <= de;
      pixel_q     <= out_pop ? head[PIXEL_WIDTH-1:0] : FILL_PIXEL;
      underflow_q <= err_evt;
      if (err_evt && (err_q != '1)) begin
        err_q <= err_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign de_out    = de_out_q;
  assign pixel_out = pixel_q;
  assign locked    = (state_q == STREAM);
  assign underflow = underflow_q;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
module tb_fifo_pixel_reader;
  import dvi_pkg::*;

  localparam int            PW    = 24;
  localparam int            CW    = 2;
  localparam logic [PW-1:0] FILL  = 24'h000000;
  localparam int            DEPTH = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic de = 1'b0;

  logic          de_out;
  logic [PW-1:0] pixel_out;
  logic          locked;
  logic          underflow;
  logic [CW-1:0] err_count;
  state_t        dbg_state;

  always #5 clk = ~clk;

  fifo_pixel_reader_if #(.PIXEL_WIDTH(PW)) fif ();

  fifo_pixel_reader #(
    .PIXEL_WIDTH (PW),
    .CNT_WIDTH   (CW),
    .FILL_PIXEL  (FILL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo        (fif.master),
    .frame_start (frame_start),
    .de          (de),
    .de_out      (de_out),
    .pixel_out   (pixel_out),
    .locked      (locked),
    .underflow   (underflow),
    .err_count   (err_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- synchronous FIFO model ----------------
  logic [PW:0] fmem [DEPTH];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int skip     = 0;   // words flushed by a reset

  assign fif.fifo_empty = (push_cnt == pop_cnt + skip);

  always @(posedge clk) begin
    if (fif.fifo_r_en && !fif.fifo_empty) begin
      fif.fifo_data <= fmem[(pop_cnt + skip) % DEPTH];
      pop_cnt       <= pop_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [PW:0] exp_q[$];   // words written and not yet consumed, oldest first
  state_t      m_st = IDLE;
  logic        m_first = 1'b0;
  int          m_err = 0;
  int          uf_seen = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_err();
    return (m_err > 3) ? 3 : m_err;
  endfunction

  task automatic push_word(input logic sof, input logic [PW-1:0] pix);
    fmem[push_cnt % DEPTH] = {sof, pix};
    push_cnt++;
    exp_q.push_back({sof, pix});
  endtask

  // Outputs expected for one cycle of frame_start/de.
  task automatic model_step(input logic fs, input logic d,
                            output logic [PW-1:0] ep, output logic eu);
    logic [PW:0] w;
    ep = FILL;
    eu = 1'b0;
    case (m_st)
      STREAM: begin
        if (d) begin
          if (exp_q.size() == 0) begin
            eu = 1'b1; m_err++; m_st = RESYNC;
          end else if (exp_q[0][PW] && !m_first) begin
            eu = 1'b1; m_err++; m_st = ARMED;
          end else begin
            w = exp_q.pop_front();
            ep = w[PW-1:0];
            m_first = 1'b0;
          end
        end
        if (fs) m_first = 1'b1;
      end
      ARMED: if (fs) begin m_st = STREAM; m_first = 1'b1; end
      default: ;
    endcase
  endtask

  // After enough idle cycles the hunting states have dropped every leading
  // untagged word and stopped on a tagged one if there is one.
  task automatic model_settle();
    if (m_st == IDLE || m_st == RESYNC) begin
      while (exp_q.size() != 0 && !exp_q[0][PW]) void'(exp_q.pop_front());
      if (exp_q.size() != 0) m_st = ARMED;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic fs, input logic d);
    logic [PW-1:0] ep;
    logic          eu;
    frame_start = fs;
    de          = d;
    model_step(fs, d, ep, eu);
    @(posedge clk);
    #1;
    if (underflow) uf_seen++;
    check("de_out", 32'(de_out), 32'(d));
    check("pixel_out", 32'(pixel_out), 32'(ep));
    check("underflow", 32'(underflow), 32'(eu));
    check("err_count", 32'(err_count), 32'(exp_err()));
    check("rd_while_empty", 32'(fif.fifo_r_en & fif.fifo_empty), 32'd0);
    frame_start = 1'b0;
    de          = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(m_st));
    check({tag, "_locked"}, 32'(locked), 32'(m_st == STREAM));
  endtask

  task automatic settle();
    int n;
    n = exp_q.size() + 8;
    repeat (n) cycle(1'b0, 1'b0);
    model_settle();
    check_state("settle");
  endtask

  task automatic run_frame(input int nde);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (nde) cycle(1'b0, 1'b1);
    check_state("frame");
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    de          = 1'b0;
    skip        = push_cnt - pop_cnt;
    exp_q.delete();
    m_st    = IDLE;
    m_first = 1'b0;
    m_err   = 0;
    #1;
    check("rst_de_out", 32'(de_out), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'(FILL));
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_r_en", 32'(fif.fifo_r_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic release_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_r_en", 32'(fif.fifo_r_en), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    // post-reset fill, words written while reset is held
    do_reset();
    push_word(1'b1, 24'h000001);
    push_word(1'b0, 24'h000002);
    push_word(1'b0, 24'h000003);
    release_reset();
    settle();
    run_frame(3);

    // leading junk
    do_reset();
    release_reset();
    push_word(1'b0, 24'hAAAAAA);
    push_word(1'b0, 24'hAAAAAA);
    push_word(1'b1, 24'h000010);
    settle();
    run_frame(1);

    // underflow: 2 words, 4 de cycles
    do_reset();
    release_reset();
    push_word(1'b1, 24'h000001);
    push_word(1'b0, 24'h000002);
    settle();
    run_frame(4);

    // mid-frame SOF: A,B then sync error, C first on the next frame
    do_reset();
    release_reset();
    push_word(1'b1, 24'h0000A0);
    push_word(1'b0, 24'h0000B0);
    push_word(1'b1, 24'h0000C0);
    settle();
    run_frame(3);
    run_frame(1);

    // saturation of the 2-bit counter over 5 underflows
    do_reset();
    release_reset();
    uf_seen = 0;
    repeat (5) begin
      push_word(1'b1, PW'($urandom));
      settle();
      run_frame(2);
    end
    check("uf_pulses", 32'(uf_seen), 32'd5);
    check("err_saturated", 32'(err_count), 32'd3);

    // asynchronous reset in the middle of a streamed frame
    do_reset();
    release_reset();
    push_word(1'b1, 24'h123456);
    for (int j = 0; j < 5; j++) push_word(1'b0, PW'($urandom));
    settle();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    de = 1'b1;
    @(posedge clk);
    #2;
    do_reset();
    push_word(1'b1, 24'h0BEEF0);
    release_reset();
    settle();
    run_frame(2);

    // randomized frames against the model
    do_reset();
    release_reset();
    for (int t = 0; t < 60; t++) begin
      int nj;
      int len;
      nj  = $urandom_range(0, 2);
      len = $urandom_range(1, 5);
      for (int j = 0; j < nj; j++) push_word(1'b0, PW'($urandom));
      push_word(1'b1, PW'($urandom));
      for (int j = 1; j < len; j++) push_word($urandom_range(0, 7) == 0, PW'($urandom));
      settle();
      run_frame($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) begin
        do_reset();
        release_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
